// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// FSM state encoding and the active-low hex glyph table.
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGuard = 2'd1,
        StDrive = 2'd2
    } scan_state_e;

    localparam logic [6:0] SegBlank = 7'h7F;

    // Bit order {g,f,e,d,c,b,a}, active-low; entry 15 is leftmost.
    localparam logic [15:0][6:0] SegTable = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_scan_ctrl_hex7seg_decode.sv
// Combinational nibble-to-segment lookup for one digit.
module hex7seg_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SegTable[nibble];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered digit data, per-slot
// anode guard time, leading-zero blanking and registered outputs.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int unsigned CntW = $clog2(SLOT_CYCLES);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CntW-1:0] SlotLast  = CntW'(SLOT_CYCLES - 1);
    localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    xfer;
    logic [3:0]              nibble;
    logic                    dp_sel;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    zero_run;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable) state_d = StGuard;
            end
            StGuard: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GuardLast) state_d = StDrive;
            end
            StDrive: begin
                if (cnt_q == SlotLast) begin
                    cnt_d   = '0;
                    idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                    state_d = StGuard;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    // Frame boundary: the edge that enters digit-0 guard, from either IDLE or a wrap.
    assign xfer = (state_d == StGuard) && (idx_d == '0) && (state_q != StGuard);

    always_comb begin
        pend_data_d  = load ? data_in : pend_data_q;
        pend_dp_d    = load ? dp_in : pend_dp_q;
        pend_valid_d = load ? 1'b1 : (xfer ? 1'b0 : pend_valid_q);
        act_data_d   = (xfer && pend_valid_q) ? pend_data_q : act_data_q;
        act_dp_d     = (xfer && pend_valid_q) ? pend_dp_q : act_dp_q;
    end

    always_comb begin
        nibble = 4'h0;
        dp_sel = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_d == IdxW'(k)) begin
                nibble = act_data_d[4*k +: 4];
                dp_sel = act_dp_d[k];
            end
        end
    end

    // Digit k blanks when it and every more-significant nibble are zero.
    always_comb begin
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            zero_run      = zero_run & (act_data_d[4*k +: 4] == 4'h0);
            blank_mask[k] = zero_run;
        end
    end

    hex7seg_decode u_decode (
        .nibble (nibble),
        .seg    (glyph)
    );

    // Outputs are computed from next-state so they line up with the state register.
    always_comb begin
        an_d         = '1;
        seg_d        = SegBlank;
        dp_d         = 1'b1;
        frame_done_d = 1'b0;
        if (state_d != StIdle) begin
            seg_d = (lz_blank && blank_mask[idx_d]) ? SegBlank : glyph;
            dp_d  = ~dp_sel;
        end
        if (state_d == StDrive) begin
            an_d[idx_d]  = 1'b0;
            frame_done_d = (idx_d == IdxLast) && (cnt_d == SlotLast);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            an_q         <= '1;
            seg_q        <= SegBlank;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 8-cycle slots, 2-cycle guard.
module tb_seg_scan_ctrl;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int t = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SLOT_CYCLES  (8),
        .GUARD_CYCLES (2)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        t++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @edge %0d: observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic e_fd);
        chk({tag, "_an"}, an, e_an);
        chk({tag, "_seg"}, seg, e_seg);
        chk({tag, "_dp"}, dp, e_dp);
        chk({tag, "_fd"}, frame_done, e_fd);
    endtask

    // Expected glyph per 32-edge frame f and slot s, from the directed load schedule.
    function automatic logic [6:0] exp_seg(int f, int s);
        case (f)
            0: return 7'h40;
            1: case (s)
                   0:       return 7'h0E;
                   1:       return 7'h08;
                   2:       return 7'h24;
                   default: return 7'h79;
               endcase
            2: return 7'h24;
            3: return 7'h30;
            4: return (s == 0) ? 7'h12 : 7'h7F;
            default: return (s == 0) ? 7'h12 : 7'h40;
        endcase
    endfunction

    initial begin
        logic [3:0] one_hot;
        int f, s, p;
        rst = 1'b1; enable = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; lz_blank = 1'b0;
        tick();
        tick();
        chk_all("reset", 4'hF, 7'h7F, 1'b1, 1'b0);

        rst = 1'b0;
        enable = 1'b1;
        t = 0;
        for (int e = 1; e <= 212; e++) begin
            load = 1'b0;
            if (e == 10)  begin load = 1'b1; data_in = 16'h12AF; dp_in = 4'b0010; end
            if (e == 40)  begin load = 1'b1; data_in = 16'h2222; dp_in = 4'b0000; end
            if (e == 65)  begin load = 1'b1; data_in = 16'h3333; end
            if (e == 105) begin load = 1'b1; data_in = 16'h0005; lz_blank = 1'b1; end
            if (e == 161) lz_blank = 1'b0;
            tick();
            f = (t - 1) / 32;
            s = ((t - 1) % 32) / 8;
            p = (t - 1) % 8;
            one_hot = 4'b0001 << s;
            chk_all("scan", (p < 2) ? 4'hF : ~one_hot, exp_seg(f, s),
                    (f == 1 && s == 1) ? 1'b0 : 1'b1, (t % 32) == 0);
        end

        // Edge 212 is DRIVE of digit 2; dropping enable goes dark on the next edge.
        load = 1'b0;
        enable = 1'b0;
        tick();
        chk_all("disable", 4'hF, 7'h7F, 1'b1, 1'b0);
        load = 1'b1; data_in = 16'h0008; dp_in = 4'b0001;
        tick();
        load = 1'b0;
        chk_all("idle_load", 4'hF, 7'h7F, 1'b1, 1'b0);

        enable = 1'b1;
        tick();
        chk_all("restart_g0", 4'hF, 7'h00, 1'b0, 1'b0);
        tick();
        chk("restart_g1_an", an, 4'hF);
        tick();
        chk_all("restart_d0", 4'hE, 7'h00, 1'b0, 1'b0);
        for (int e = 218; e <= 246; e++) begin
            tick();
            if (t == 225) chk_all("restart_d1", 4'hD, 7'h40, 1'b1, 1'b0);
            chk("restart_fd", frame_done, t == 246);
        end

        // Reset lands on the frame_done cycle.
        rst = 1'b1;
        tick();
        chk_all("rst_on_fd", 4'hF, 7'h7F, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("post_rst_g0", 4'hF, 7'h40, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits.
REQ-002 SHALL have parameter SLOT_CYCLES, default 100000: clk_in cycles per digit slot; legal range is 8 or more.
REQ-003 SHALL have parameter GUARD_CYCLES, default 16: anode-off cycles at each slot start; legal range is 1 to SLOT_CYCLES-2.
REQ-004 One clock, clk_in; reset rst is synchronous and active-high.
REQ-005 clk_in  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 enable  input  1  1 = scanning; 0 = display dark.
REQ-008 load  input  1  one-cycle strobe; captures data_in and dp_in.
REQ-009 data_in  input  4*NUM_DIGITS  hex nibbles; nibble 0 (LSBs) is the rightmost digit.
REQ-010 dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-011 lz_blank  input  1  1 = blank leading zeros.
REQ-012 an  output  NUM_DIGITS  anode selects, active-low.
REQ-013 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 dp  output  1  decimal point, active-low.
REQ-015 frame_done  output  1  one-cycle pulse at the end of the last digit slot.

Function
REQ-016 load=1 SHALL copy data_in/dp_in into the pending register and set pend_valid; a later load before transfer overwrites.
REQ-017 The pending register SHALL transfer to the active register, clearing pend_valid, only on the cycle entering GUARD for digit 0; there is no tearing within a frame.
REQ-018 Digit index idx SHALL count 0..NUM_DIGITS-1 and wrap to 0; slot counter cnt SHALL count 0..SLOT_CYCLES-1.
REQ-019 FSM states SHALL be IDLE, GUARD, DRIVE.
- IDLE: an, seg and dp all ones; cnt=0; idx=0.
- IDLE -> GUARD when enable=1.
REQ-020 GUARD: an SHALL be all ones, with seg/dp already showing digit idx.
- GUARD -> DRIVE when cnt==GUARD_CYCLES-1.
REQ-021 DRIVE: an[idx]=0 and all other anode bits 1.
- At cnt==SLOT_CYCLES-1: cnt->0, idx->idx+1 mod NUM_DIGITS, DRIVE -> GUARD.
REQ-022 frame_done SHALL pulse high for exactly one cycle on the last DRIVE cycle of idx=NUM_DIGITS-1.
REQ-023 enable=0 in any state SHALL force IDLE on the next edge. Re-enable SHALL restart at digit 0 GUARD. A pending update SHALL be taken at that restart.
REQ-024 The decoder SHALL map hex 0-F to standard 7-segment glyphs (0 -> seg=7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110).
REQ-025 With lz_blank=1, digit k>0 SHALL show seg=7'h7F when all active nibbles k..NUM_DIGITS-1 are zero. Digit 0 is never blanked.
REQ-026 dp SHALL be ~active_dp[idx] and SHALL NOT be blanked by lz_blank.
REQ-027 All outputs SHALL be registered. an/seg/dp change one cycle after the state/cnt condition that causes them.
REQ-028 load and the frame transfer in the same cycle: the transfer SHALL use the old pending value. The new value SHALL be stored pending, pend_valid=1.

Reset
REQ-029 rst=1 SHALL force IDLE, cnt=0, idx=0, an all ones, seg=7'h7F, dp=1, frame_done=0.
REQ-030 rst=1 SHALL clear the active and pending registers and pend_valid; rst mid-slot aborts the slot with no glitch pulse on frame_done.
REQ-031 rst SHALL take priority over enable and load.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (IDLE/GUARD/DRIVE) and the 16-entry hex-to-segment constant table.
REQ-033 A single sub-module hex7seg_decode SHALL provide the combinational nibble-to-seg lookup. Counters and the FSM stay in seg_scan_ctrl.

Verification (bench with NUM_DIGITS=4, SLOT_CYCLES=8, GUARD_CYCLES=2)
REQ-034 Reset, then enable=1 for 32 cycles -> an sequence per slot is 1111,1111,1110x6, then 1111x2,1101x6, and so on; frame_done pulses once at cycle 32.
REQ-035 load data_in=16'h12AF mid-frame -> the old value is shown until the next digit-0 GUARD, then seg for digits 0..3 = F,A,2,1.
REQ-036 data_in=16'h0005, lz_blank=1 -> digits 3..1 seg=7'h7F and digit 0 shows 5; with lz_blank=0, digits 3..1 show 0.
REQ-037 enable dropped during the DRIVE of digit 2 -> the next cycle is IDLE with all outputs high; re-enable starts at digit 0 GUARD.
REQ-038 load asserted in the frame-transfer cycle with 16'h3333 while 16'h2222 is pending -> this frame shows 2222 and the next frame shows 3333.
REQ-039 rst asserted on the frame_done cycle -> frame_done=0 at the next edge; all outputs reach reset values in one cycle.
